priority_arbiter_rr: RTL and testbench

Parametrised, registered successor to the 8-input priority encoder. It arbitrates N request lines and holds one grant until the owner releases it, drops its request, or exceeds a hold limit. Runtime mode selects fixed priority (highest index wins, as in the 8-bit encoder) or round-robin. It sits in front of shared resources (bus, memory port) that the combinational encoder cannot arbitrate fairly.

---
 rtl/priority_arbiter_rr.sv | 163 ++++++++++++++++
 tb/tb_priority_arbiter_rr.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/priority_arbiter_rr.sv
// N-input registered arbiter that holds one grant at a time. Selection is runtime-selectable
// between fixed priority (highest index wins) and round-robin, with an optional hold limit.
module priority_arbiter_rr #(
    parameter int N        = 8,
    parameter int CW       = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    input  logic          mode_i,
    input  logic [N-1:0]  req_i,
    input  logic          release_i,
    output logic          gnt_valid_o,
    output logic [CW-1:0] gnt_code_o,
    output logic [N-1:0]  gnt_onehot_o,
    output logic          gnt_timeout_o
);

    localparam int              HW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0]   HOLD_LAST = HW'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
    localparam logic [N-1:0]    ONE_N     = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] code_q, code_d;
    logic [N-1:0]  onehot_q, onehot_d;
    logic [CW-1:0] ptr_q, ptr_d;
    logic [HW-1:0] hold_q, hold_d;

    logic          cur_req_s;
    logic          hold_last_s;
    logic          rel_s;
    logic [CW-1:0] ptr_inc_s;
    logic [N-1:0]  arb_vec_s;
    logic [CW-1:0] arb_ptr_s;
    logic [CW-1:0] win_s;

    function automatic logic [CW-1:0] pick_fixed(input logic [N-1:0] v);
        logic [CW-1:0] w;
        w = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                w = CW'(i);
            end
        end
        return w;
    endfunction

    function automatic logic [CW-1:0] pick_rr(input logic [N-1:0] v, input logic [CW-1:0] p);
        logic [CW-1:0] w;
        logic [CW-1:0] k;
        logic          hit;
        w   = '0;
        hit = 1'b0;
        for (int i = 0; i < N; i++) begin
            k = CW'((int'(p) + i) % N);
            if (!hit && v[k]) begin
                w   = k;
                hit = 1'b1;
            end
        end
        return w;
    endfunction

    // Release detection and the candidate vector / pointer used for this cycle's arbitration.
    always_comb begin
        cur_req_s   = req_i[code_q];
        hold_last_s = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
        rel_s       = (state_q == ST_GRANT) && (release_i || !cur_req_s || hold_last_s);
        ptr_inc_s   = (code_q == CW'(N - 1)) ? '0 : (code_q + CW'(1));
        if (rel_s) begin
            // Onehot register equals 1<<cur while granted, so it doubles as the owner mask.
            arb_vec_s = req_i & ~onehot_q;
            arb_ptr_s = ptr_inc_s;
        end else begin
            arb_vec_s = req_i;
            arb_ptr_s = ptr_q;
        end
        if (mode_i) begin
            win_s = pick_rr(arb_vec_s, arb_ptr_s);
        end else begin
            win_s = pick_fixed(arb_vec_s);
        end
    end

    // Next-state logic for the IDLE/GRANT machine and the grant registers.
    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        onehot_d = onehot_q;
        ptr_d    = ptr_q;
        hold_d   = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (en_i && (arb_vec_s != '0)) begin
                    state_d  = ST_GRANT;
                    code_d   = win_s;
                    onehot_d = ONE_N << win_s;
                    hold_d   = '0;
                end else begin
                    state_d  = ST_IDLE;
                    code_d   = '0;
                    onehot_d = '0;
                    hold_d   = '0;
                end
            end
            ST_GRANT: begin
                if (rel_s) begin
                    ptr_d = ptr_inc_s;
                    if (en_i && (arb_vec_s != '0)) begin
                        state_d  = ST_GRANT;
                        code_d   = win_s;
                        onehot_d = ONE_N << win_s;
                        hold_d   = '0;
                    end else begin
                        state_d  = ST_IDLE;
                        code_d   = '0;
                        onehot_d = '0;
                        hold_d   = '0;
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                state_d  = ST_IDLE;
                code_d   = '0;
                onehot_d = '0;
                ptr_d    = '0;
                hold_d   = '0;
            end
        endcase
    end

    // State and grant registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            code_q   <= '0;
            onehot_q <= '0;
            ptr_q    <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            onehot_q <= onehot_d;
            ptr_q    <= ptr_d;
            hold_q   <= hold_d;
        end
    end

    assign gnt_valid_o   = (state_q == ST_GRANT);
    assign gnt_code_o    = code_q;
    assign gnt_onehot_o  = onehot_q;
    // Flags the final cycle of a grant that the hold limit, not the owner, is ending.
    assign gnt_timeout_o = (state_q == ST_GRANT) && hold_last_s && !release_i && cur_req_s;

endmodule

// File: tb/tb_priority_arbiter_rr.sv
// Directed scoreboard bench for priority_arbiter_rr with N=8, MAX_HOLD=4.
module tb_priority_arbiter_rr;

    localparam int N  = 8;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          mode = 1'b0;
    logic [N-1:0]  req = '0;
    logic          rel = 1'b0;
    logic          gnt_valid;
    logic [CW-1:0] gnt_code;
    logic [N-1:0]  gnt_onehot;
    logic          gnt_timeout;

    int checks   = 0;
    int failures = 0;
    int step_no  = 0;

    typedef struct {
        string         tag;
        logic          v;
        logic [CW-1:0] c;
    } exp_t;

    exp_t sb[$];

    priority_arbiter_rr #(.N(N), .CW(CW), .MAX_HOLD(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en_i          (en),
        .mode_i        (mode),
        .req_i         (req),
        .release_i     (rel),
        .gnt_valid_o   (gnt_valid),
        .gnt_code_o    (gnt_code),
        .gnt_onehot_o  (gnt_onehot),
        .gnt_timeout_o (gnt_timeout)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check the same-cycle timeout flag, queue the expected
    // post-edge grant, then pop and compare it after the edge.
    task automatic cyc(input string name, input logic r_n, input logic [N-1:0] r, input logic e,
                       input logic m, input logic rl, input logic ev, input logic [CW-1:0] ec,
                       input logic eto);
        exp_t item;
        exp_t got;
        logic [N-1:0] oh;
        @(negedge clk);
        rst_n = r_n; req = r; en = e; mode = m; rel = rl;
        step_no++;
        #1;
        check_val($sformatf("%s#%0d timeout", name, step_no), {31'd0, gnt_timeout}, {31'd0, eto});
        item.tag = $sformatf("%s#%0d", name, step_no);
        item.v   = ev;
        item.c   = ec;
        sb.push_back(item);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check_val("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            got = sb.pop_front();
            oh  = got.v ? (8'd1 << got.c) : 8'd0;
            check_val({got.tag, " valid"},  {31'd0, gnt_valid},  {31'd0, got.v});
            check_val({got.tag, " code"},   {29'd0, gnt_code},   {29'd0, (got.v ? got.c : 3'd0)});
            check_val({got.tag, " onehot"}, {24'd0, gnt_onehot}, {24'd0, oh});
        end
    endtask

    initial begin
        // Initial reset edge to bring the DUT out of X before checking.
        rst_n = 1'b0; req = 8'hFF; en = 1'b1;
        @(posedge clk);

        // 1: reset holds outputs low, and clears a live grant.
        cyc("rst",   1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        cyc("rst",   1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        cyc("rstg",  1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 3'd7, 1'b0);
        cyc("rstg",  1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 3'd7, 1'b0);
        cyc("rstm",  1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);

        // 2: fixed priority, back-to-back handover on release.
        cyc("fix",   1'b1, 8'h44, 1'b1, 1'b0, 1'b0, 1'b1, 3'd6, 1'b0);
        cyc("fix",   1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0);
        cyc("fix",   1'b1, 8'h04, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
        cyc("fix",   1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);

        // 3: round-robin rotation from pointer 0, then switch to fixed.
        cyc("rrst",  1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        cyc("rr",    1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            cyc("rr", 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, CW'(i % 8), 1'b0);
        end
        cyc("rr2fix", 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 3'd7, 1'b0);
        cyc("rrend",  1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);

        // 4a: hold limit with a single requester: 4 cycles, pulse, one idle cycle, regrant.
        for (int i = 0; i < 4; i++) begin
            cyc("to1", 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
        end
        cyc("to1", 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
        cyc("to1", 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
        cyc("to1", 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);

        // 4b: hold limit in round-robin hands over without a gap, wrapping back to 0.
        cyc("to2rst", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc("to2", 1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0);
        end
        cyc("to2", 1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc("to2", 1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0);
        end
        cyc("to2", 1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 1'b1);
        cyc("to2", 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);

        // 5: owner drops its request.
        cyc("drop",  1'b1, 8'h2F, 1'b1, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0);
        cyc("drop",  1'b1, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0);
        cyc("drop",  1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);

        // 6: enable gating, and en=0 during a grant blocks re-arbitration.
        for (int i = 0; i < 5; i++) begin
            cyc("en0", 1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        end
        cyc("en1",   1'b1, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1, 3'd7, 1'b0);
        cyc("enoff", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7, 1'b0);
        cyc("enoff", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
        cyc("enoff", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        cyc("idrel", 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
